// File: rtl/pe_array_pkg.sv
// Shared types and constants for the 3x3 row-stationary PE array sequencer.
package pe_array_pkg;

    localparam int DATA_W  = 8;
    localparam int IF_DIM  = 5;
    localparam int K       = 3;
    localparam int OUT_DIM = IF_DIM - K + 1;
    localparam int COL_W   = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        OUT   = 3'd4
    } state_e;

    // Flat index of output element (row r, column c) in the result buffer.
    function automatic int elem(input int r, input int c);
        return r * OUT_DIM + c;
    endfunction

endpackage

// File: rtl/pe_array_seq_ctrl_psum_collect.sv
// Psum capture for one tile: latency counter, capture counter and the
// OUT_DIM x OUT_DIM result register file.
module psum_collect
    import pe_array_pkg::*;
#(
    parameter int PIPE_LAT = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clr,
    input  logic                              active,
    input  logic [K*DATA_W-1:0]               psum_flat,
    output logic [OUT_DIM*OUT_DIM*DATA_W-1:0] result_flat,
    output logic                              last_capture
);

    localparam int LAT_W = (PIPE_LAT < 1) ? 1 : $clog2(PIPE_LAT + 1);
    localparam logic [LAT_W-1:0] LAT_MAX  = LAT_W'(PIPE_LAT);
    localparam logic [COL_W-1:0] CAP_NUM  = COL_W'(OUT_DIM);
    localparam logic [COL_W-1:0] CAP_LAST = COL_W'(OUT_DIM - 1);

    logic [LAT_W-1:0]                  lat_q, lat_d;
    logic [COL_W-1:0]                  cap_q, cap_d;
    logic [OUT_DIM*OUT_DIM*DATA_W-1:0] result_q, result_d;
    logic                              capture;

    // The result buffer is deliberately not cleared by clr: it keeps the
    // previous tile until this tile's first capture overwrites column 0.
    always_comb begin
        lat_d    = lat_q;
        cap_d    = cap_q;
        result_d = result_q;
        capture  = 1'b0;
        if (clr) begin
            lat_d = '0;
            cap_d = '0;
        end else if (active) begin
            capture = (lat_q >= LAT_MAX) && (cap_q < CAP_NUM);
            if (lat_q < LAT_MAX) begin
                lat_d = lat_q + 1'b1;
            end
            if (capture) begin
                for (int r = 0; r < K; r++) begin
                    result_d[elem(r, int'(cap_q))*DATA_W +: DATA_W] =
                        psum_flat[r*DATA_W +: DATA_W];
                end
                cap_d = cap_q + 1'b1;
            end
        end
        last_capture = capture && (cap_q == CAP_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_q    <= '0;
            cap_q    <= '0;
            result_q <= '0;
        end else begin
            lat_q    <= lat_d;
            cap_q    <= cap_d;
            result_q <= result_d;
        end
    end

    assign result_flat = result_q;

endmodule

// File: rtl/pe_array_seq_ctrl.sv
// Sequencer for the 3x3 row-stationary PE array: accepts a tile, clears and
// steps the array column by column, and presents the collected 3x3 result.
module pe_array_seq_ctrl
    import pe_array_pkg::*;
#(
    parameter int PIPE_LAT = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [IF_DIM*IF_DIM*DATA_W-1:0]   ifmap_flat,
    input  logic [K*K*DATA_W-1:0]             filter_flat,
    output logic                              arr_clr,
    output logic                              arr_en,
    output logic [2:0]                        arr_col,
    output logic [IF_DIM*IF_DIM*DATA_W-1:0]   arr_ifmap_flat,
    output logic [K*K*DATA_W-1:0]             arr_filter_flat,
    input  logic [K*DATA_W-1:0]               arr_psum_flat,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [OUT_DIM*OUT_DIM*DATA_W-1:0] out_data_flat,
    output logic                              busy,
    output logic                              done,
    output logic [2:0]                        dbg_state
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(OUT_DIM - 1);

    // Handshakes: a transfer happens on a rising clk edge where valid and
    // ready are both high; valid never depends on ready, and once out_valid
    // is raised it and out_data_flat hold until the transfer completes.

    state_e                            state_q, state_d;
    logic [COL_W-1:0]                  issue_q, issue_d;
    logic [IF_DIM*IF_DIM*DATA_W-1:0]   ifmap_q, ifmap_d;
    logic [K*K*DATA_W-1:0]             filter_q, filter_d;
    logic                              coll_clr;
    logic                              coll_active;
    logic                              last_capture;

    always_comb begin
        state_d     = state_q;
        issue_d     = issue_q;
        ifmap_d     = ifmap_q;
        filter_d    = filter_q;
        in_ready    = 1'b0;
        arr_clr     = 1'b0;
        arr_en      = 1'b0;
        out_valid   = 1'b0;
        done        = 1'b0;
        busy        = 1'b1;
        coll_clr    = 1'b0;
        coll_active = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    ifmap_d  = ifmap_flat;
                    filter_d = filter_flat;
                    state_d  = CLEAR;
                end
            end
            CLEAR: begin
                arr_clr  = 1'b1;
                coll_clr = 1'b1;
                issue_d  = '0;
                state_d  = RUN;
            end
            RUN: begin
                arr_en      = 1'b1;
                coll_active = 1'b1;
                // With no pipeline latency the final capture lands on the
                // final issue, so DRAIN is skipped.
                if (last_capture) begin
                    state_d = OUT;
                end else if (issue_q == LAST_COL) begin
                    state_d = DRAIN;
                end else begin
                    issue_d = issue_q + 1'b1;
                end
            end
            DRAIN: begin
                coll_active = 1'b1;
                if (last_capture) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            issue_q  <= '0;
            ifmap_q  <= '0;
            filter_q <= '0;
        end else begin
            state_q  <= state_d;
            issue_q  <= issue_d;
            ifmap_q  <= ifmap_d;
            filter_q <= filter_d;
        end
    end

    psum_collect #(
        .PIPE_LAT(PIPE_LAT)
    ) u_collect (
        .clk         (clk),
        .rst         (rst),
        .clr         (coll_clr),
        .active      (coll_active),
        .psum_flat   (arr_psum_flat),
        .result_flat (out_data_flat),
        .last_capture(last_capture)
    );

    assign arr_col         = issue_q;
    assign arr_ifmap_flat  = ifmap_q;
    assign arr_filter_flat = filter_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_pe_array_seq_ctrl.sv
// Self-checking bench for pe_array_seq_ctrl with a behavioural PE array model
// and an expected-result scoreboard.
module tb_pe_array_seq_ctrl;
    import pe_array_pkg::*;

    localparam int IFW = IF_DIM * IF_DIM * DATA_W;
    localparam int FW  = K * K * DATA_W;
    localparam int RW  = OUT_DIM * OUT_DIM * DATA_W;
    localparam int PW  = K * DATA_W;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [IFW-1:0] ifmap_flat;
    logic [FW-1:0]  filter_flat;
    logic           arr_clr;
    logic           arr_en;
    logic [2:0]     arr_col;
    logic [IFW-1:0] arr_ifmap_flat;
    logic [FW-1:0]  arr_filter_flat;
    logic [PW-1:0]  arr_psum_flat;
    logic           out_valid;
    logic           out_ready;
    logic [RW-1:0]  out_data_flat;
    logic           busy;
    logic           done;
    logic [2:0]     dbg_state;

    int checks = 0;
    int errors = 0;
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] exp_v;
    logic [2:0] col_d1 = '0;
    logic [2:0] col_d2 = '0;

    pe_array_seq_ctrl #(.PIPE_LAT(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .ifmap_flat     (ifmap_flat),
        .filter_flat    (filter_flat),
        .arr_clr        (arr_clr),
        .arr_en         (arr_en),
        .arr_col        (arr_col),
        .arr_ifmap_flat (arr_ifmap_flat),
        .arr_filter_flat(arr_filter_flat),
        .arr_psum_flat  (arr_psum_flat),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data_flat  (out_data_flat),
        .busy           (busy),
        .done           (done),
        .dbg_state      (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Convolution of one output element, wrapping at DATA_W bits.
    function automatic logic [DATA_W-1:0] conv_at(input logic [IFW-1:0] ifm,
                                                  input logic [FW-1:0] flt,
                                                  input int r, input int c);
        logic [DATA_W-1:0] acc;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        acc = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                a   = ifm[((r + i) * IF_DIM + c + j) * DATA_W +: DATA_W];
                b   = flt[(i * K + j) * DATA_W +: DATA_W];
                acc = acc + a * b;
            end
        end
        return acc;
    endfunction

    function automatic logic [RW-1:0] calc_result(input logic [IFW-1:0] ifm,
                                                   input logic [FW-1:0] flt);
        logic [RW-1:0] res;
        res = '0;
        for (int r = 0; r < OUT_DIM; r++) begin
            for (int c = 0; c < OUT_DIM; c++) begin
                res[(r * OUT_DIM + c) * DATA_W +: DATA_W] = conv_at(ifm, flt, r, c);
            end
        end
        return res;
    endfunction

    function automatic logic [IFW-1:0] fill_ifmap(input logic [7:0] v);
        logic [IFW-1:0] x;
        for (int k = 0; k < IF_DIM * IF_DIM; k++) x[k*DATA_W +: DATA_W] = v;
        return x;
    endfunction

    function automatic logic [FW-1:0] fill_filter(input logic [7:0] v);
        logic [FW-1:0] x;
        for (int k = 0; k < K * K; k++) x[k*DATA_W +: DATA_W] = v;
        return x;
    endfunction

    function automatic logic [IFW-1:0] rand_ifmap();
        logic [IFW-1:0] x;
        for (int k = 0; k < IF_DIM * IF_DIM; k++) x[k*DATA_W +: DATA_W] = 8'($urandom_range(0, 255));
        return x;
    endfunction

    function automatic logic [FW-1:0] rand_filter();
        logic [FW-1:0] x;
        for (int k = 0; k < K * K; k++) x[k*DATA_W +: DATA_W] = 8'($urandom_range(0, 255));
        return x;
    endfunction

    // PE array model: two-stage pipeline from arr_col to the column psums.
    always @(posedge clk) begin
        col_d1 <= arr_col;
        col_d2 <= col_d1;
    end

    always_comb begin
        arr_psum_flat = '0;
        if (int'(col_d2) < OUT_DIM) begin
            for (int r = 0; r < K; r++) begin
                arr_psum_flat[r*DATA_W +: DATA_W] =
                    conv_at(arr_ifmap_flat, arr_filter_flat, r, int'(col_d2));
            end
        end
    end

    // Scoreboard: every output handshake pops and compares one expected tile.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty: got %h with no tile expected", out_data_flat);
            end else begin
                exp_v = exp_q.pop_front();
                if (out_data_flat !== exp_v) begin
                    errors++;
                    $display("FAIL scoreboard_data: got %h exp %h", out_data_flat, exp_v);
                end
            end
        end
    end

    task automatic send_tile(input logic [IFW-1:0] ifm, input logic [FW-1:0] flt);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        in_valid    = 1'b1;
        ifmap_flat  = ifm;
        filter_flat = flt;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            exp_q.push_back(calc_result(ifm, flt));
        end else begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready got 0 exp 1 within 100 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Called right after the acceptance edge; cyc is the index of the first
    // cycle with out_valid high, leak flags in_ready/!busy seen before that.
    task automatic run_until_out(output int cyc, output bit leak);
        cyc  = -1;
        leak = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                cyc = i;
                break;
            end
            if (in_ready || !busy) leak = 1'b1;
        end
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending got %0d exp 0", exp_q.size());
        end
        #1;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        ifmap_flat  = '0;
        filter_flat = '0;
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
        checks++; if (arr_clr !== 1'b0) begin errors++; $display("FAIL reset_arr_clr: got %b exp 0", arr_clr); end
        checks++; if (arr_en !== 1'b0) begin errors++; $display("FAIL reset_arr_en: got %b exp 0", arr_en); end
        checks++; if (arr_col !== 3'd0) begin errors++; $display("FAIL reset_arr_col: got %0d exp 0", arr_col); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
        checks++; if (out_data_flat !== '0) begin errors++; $display("FAIL reset_out_data: got %h exp 0", out_data_flat); end
        checks++; if (arr_ifmap_flat !== '0 || arr_filter_flat !== '0) begin errors++; $display("FAIL reset_operands: got %h/%h exp 0", arr_ifmap_flat, arr_filter_flat); end
        checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", dbg_state); end
        #2;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got in_ready=%b busy=%b exp 1/0", in_ready, busy); end
    endtask

    task automatic test_identity();
        logic [IFW-1:0] ifm;
        logic [FW-1:0]  flt;
        int cyc;
        bit leak;
        for (int k = 0; k < IF_DIM * IF_DIM; k++) ifm[k*DATA_W +: DATA_W] = 8'(k);
        flt = '0;
        flt[4*DATA_W +: DATA_W] = 8'd1;
        out_ready = 1'b1;
        send_tile(ifm, flt);
        run_until_out(cyc, leak);
        checks++; if (cyc !== 6) begin errors++; $display("FAIL identity_latency: got %0d exp 6", cyc); end
        checks++; if (leak) begin errors++; $display("FAIL identity_busy: got in_ready/idle mid-tile exp busy"); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL identity_done: got %b exp 1", done); end
        for (int r = 0; r < OUT_DIM; r++) begin
            for (int c = 0; c < OUT_DIM; c++) begin
                checks++;
                if (out_data_flat[(r*OUT_DIM+c)*DATA_W +: DATA_W] !== 8'((r + 1) * IF_DIM + c + 1)) begin
                    errors++;
                    $display("FAIL identity_elem_%0d_%0d: got %0d exp %0d", r, c,
                             out_data_flat[(r*OUT_DIM+c)*DATA_W +: DATA_W], (r + 1) * IF_DIM + c + 1);
                end
            end
        end
        @(negedge clk);
        checks++; if (done !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL identity_after: got done=%b out_valid=%b in_ready=%b exp 0/0/1", done, out_valid, in_ready);
        end
        wait_drain();
    endtask

    task automatic test_all_ones_b2b();
        int cyc;
        bit leak;
        out_ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            send_tile(fill_ifmap(8'(t + 1)), fill_filter(8'd1));
            run_until_out(cyc, leak);
            checks++; if (cyc !== 6) begin errors++; $display("FAIL b2b_latency_%0d: got %0d exp 6", t, cyc); end
            checks++; if (leak) begin errors++; $display("FAIL b2b_in_ready_%0d: got in_ready high mid-tile exp low", t); end
            for (int e = 0; e < OUT_DIM * OUT_DIM; e++) begin
                checks++;
                if (out_data_flat[e*DATA_W +: DATA_W] !== 8'(9 * (t + 1))) begin
                    errors++;
                    $display("FAIL b2b_elem_%0d_%0d: got %0d exp %0d", t, e, out_data_flat[e*DATA_W +: DATA_W], 9 * (t + 1));
                end
            end
        end
        wait_drain();
    endtask

    task automatic test_backpressure();
        int cyc;
        bit leak;
        logic [IFW-1:0] ifm_b;
        logic [FW-1:0]  flt_b;
        out_ready = 1'b0;
        send_tile(rand_ifmap(), rand_filter());
        run_until_out(cyc, leak);
        checks++; if (cyc !== 6) begin errors++; $display("FAIL bp_latency: got %0d exp 6", cyc); end
        ifm_b = rand_ifmap();
        flt_b = rand_filter();
        @(posedge clk);
        #1;
        in_valid    = 1'b1;
        ifmap_flat  = ifm_b;
        filter_flat = flt_b;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0 ||
                exp_q.size() == 0 || out_data_flat !== exp_q[0]) begin
                errors++;
                $display("FAIL bp_hold_%0d: got out_valid=%b in_ready=%b done=%b data=%h exp 1/0/0 held result",
                         i, out_valid, in_ready, done, out_data_flat);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done: got %b exp 1", done); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_next_accept: got in_ready=%b exp 1", in_ready); end
        exp_q.push_back(calc_result(ifm_b, flt_b));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        run_until_out(cyc, leak);
        checks++; if (cyc !== 6) begin errors++; $display("FAIL bp_second_latency: got %0d exp 6", cyc); end
        wait_drain();
    endtask

    task automatic test_reset_abort();
        bit found;
        int cyc;
        bit leak;
        found     = 1'b0;
        out_ready = 1'b1;
        send_tile(rand_ifmap(), rand_filter());
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (arr_en && arr_col == 3'd1) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (!found) begin errors++; $display("FAIL abort_reach_col1: got no RUN col 1 exp within 20 cycles"); end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || arr_en !== 1'b0 || arr_clr !== 1'b0 || arr_col !== 3'd0 ||
            out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || out_data_flat !== '0 ||
            arr_ifmap_flat !== '0) begin
            errors++;
            $display("FAIL abort_async: got in_ready=%b en=%b clr=%b col=%0d ov=%b done=%b busy=%b exp reset values",
                     in_ready, arr_en, arr_clr, arr_col, out_valid, done, busy);
        end
        exp_q.delete();
        @(negedge clk);
        #2;
        rst = 1'b0;
        send_tile(rand_ifmap(), rand_filter());
        run_until_out(cyc, leak);
        checks++; if (cyc !== 6) begin errors++; $display("FAIL abort_fresh_latency: got %0d exp 6", cyc); end
        wait_drain();
    endtask

    task automatic test_continuous_valid();
        logic [IFW-1:0] pat[2];
        logic [FW-1:0]  flt;
        int accepted;
        int last_acc;
        bit gap_bad;
        pat[0]   = rand_ifmap();
        pat[1]   = ~pat[0];
        flt      = rand_filter();
        accepted = 0;
        last_acc = -1;
        gap_bad  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid    = 1'b1;
        ifmap_flat  = pat[0];
        filter_flat = flt;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(calc_result(ifmap_flat, filter_flat));
                if (last_acc >= 0 && (i - last_acc) != 8) gap_bad = 1'b1;
                last_acc = i;
                accepted++;
                @(posedge clk);
                #1;
                if (accepted == 4) begin
                    in_valid = 1'b0;
                    break;
                end
                ifmap_flat = pat[accepted % 2];
            end
        end
        in_valid = 1'b0;
        checks++; if (accepted !== 4) begin errors++; $display("FAIL cont_accepts: got %0d exp 4", accepted); end
        checks++; if (gap_bad) begin errors++; $display("FAIL cont_gap: got acceptance spacing != 8 exp 8"); end
        wait_drain();
    endtask

    task automatic test_wrap();
        int cyc;
        bit leak;
        out_ready = 1'b1;
        send_tile(fill_ifmap(8'h80), fill_filter(8'h02));
        run_until_out(cyc, leak);
        checks++; if (cyc !== 6) begin errors++; $display("FAIL wrap_latency: got %0d exp 6", cyc); end
        checks++; if (out_data_flat !== '0) begin errors++; $display("FAIL wrap_data: got %h exp 0", out_data_flat); end
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_identity();
        test_all_ones_b2b();
        test_backpressure();
        test_reset_abort();
        test_continuous_valid();
        test_wrap();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_queue: got %0d pending exp 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish exp finish by 500us");
        $fatal(1);
    end

endmodule
